// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving port C (CPU) and port D (debug/loader) shared access to the
// negedge-clocked ram, plus decode of the LED register and switch inputs.
module mem_arbiter #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 9,
    parameter int                RAM_AW   = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        c_cmd,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic [1:0]        d_cmd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_write,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [RAM_AW-1:0] ram_raddr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic       PORT_C    = 1'b0;
    localparam logic       PORT_D    = 1'b1;

    state_t              state, state_d;
    logic [1:0]          lat_cmd;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                owner, last_owner;
    logic                grant, grant_d;
    logic                c_req, d_req;
    logic                lat_write, in_ram;
    logic [DATA_W-1:0]   rd_data;

    assign c_req     = (c_cmd == CMD_READ) || (c_cmd == CMD_WRITE);
    assign d_req     = (d_cmd == CMD_READ) || (d_cmd == CMD_WRITE);
    assign lat_write = (lat_cmd == CMD_WRITE);
    assign in_ram    = (lat_addr >> RAM_AW) == '0;

    assign ram_raddr = lat_addr[RAM_AW-1:0];
    assign ram_waddr = lat_addr[RAM_AW-1:0];
    assign ram_wdata = lat_wdata;
    // Decoded from state so an asynchronous reset kills a pending write at once
    assign ram_write = (state == ACCESS) && lat_write && in_ram;
    assign busy      = (state != IDLE);

    always_comb begin
        rd_data = '0;
        if (in_ram)
            rd_data = ram_rdata;
        else if (lat_addr == SW_ADDR)
            rd_data = {{(DATA_W-8){1'b0}}, sw_in};
        else if (lat_addr == LED_ADDR)
            rd_data = {{(DATA_W-8){1'b0}}, led_out};
    end

    // In RESP the port just served is masked, so only the other port can be granted
    always_comb begin
        state_d = state;
        grant   = 1'b0;
        grant_d = PORT_C;
        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    grant   = 1'b1;
                    grant_d = d_req && (!c_req || last_owner == PORT_C);
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if ((owner == PORT_C) ? d_req : c_req) begin
                    grant   = 1'b1;
                    grant_d = (owner == PORT_C);
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cmd    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            owner      <= PORT_C;
            last_owner <= PORT_D;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
            led_out    <= '0;
        end else begin
            state <= state_d;
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            if (grant) begin
                lat_cmd    <= grant_d ? d_cmd   : c_cmd;
                lat_addr   <= grant_d ? d_addr  : c_addr;
                lat_wdata  <= grant_d ? d_wdata : c_wdata;
                owner      <= grant_d;
                last_owner <= grant_d;
            end
            if (state == ACCESS) begin
                if (owner == PORT_D) begin
                    d_rdata <= rd_data;
                    d_ack   <= 1'b1;
                end else begin
                    c_rdata <= rd_data;
                    c_ack   <= 1'b1;
                end
                if (lat_write && lat_addr == LED_ADDR)
                    led_out <= lat_wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a negedge ram model, a scoreboard of expected acks
// (port, ack cycle, read data) and one task per scenario.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  c_cmd, d_cmd;
    logic [8:0]  c_addr, d_addr;
    logic [15:0] c_wdata, d_wdata;
    logic        c_ack, d_ack;
    logic [15:0] c_rdata, d_rdata;
    logic        ram_write;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [7:0]  sw_in, led_out;
    logic        busy;

    typedef struct {
        bit          port;
        bit          chk;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [256];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rw_cycles = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .c_cmd     (c_cmd),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack),
        .c_rdata   (c_rdata),
        .d_cmd     (d_cmd),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .ram_write (ram_write),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[7]    = 16'h1111;
        mem[9]    = 16'h2222;
        ram_rdata = 16'h0000;
    end

    always @(negedge clk) begin
        if (ram_write) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    // Every ack is matched against the head of the scoreboard
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] obs;
        if (ram_write) rw_cycles = rw_cycles + 1;
        if (c_ack || d_ack) begin
            vectors = vectors + 1;
            obs = d_ack ? d_rdata : c_rdata;
            if (c_ack && d_ack) begin
                miscompares = miscompares + 1;
                $display("[TB] FAIL dual_ack: c_ack=%b d_ack=%b, required only one", c_ack, d_ack);
            end else if (sb.size() == 0) begin
                miscompares = miscompares + 1;
                $display("[TB] FAIL unexpected_ack: port=%0d cyc=%0d, required no ack", d_ack, cyc);
            end else begin
                e = sb.pop_front();
                if (d_ack !== e.port || cyc !== e.cyc || (e.chk && obs !== e.data)) begin
                    miscompares = miscompares + 1;
                    $display("[TB] FAIL ack: got port=%0d cyc=%0d rdata=%h, required port=%0d cyc=%0d rdata=%h",
                             d_ack, cyc, obs, e.port, e.cyc, e.chk ? e.data : obs);
                end
            end
        end
    end

    task automatic push_exp(input bit port, input bit chk, input logic [15:0] data, input int delta);
        exp_t e;
        e.port = port;
        e.chk  = chk;
        e.data = data;
        e.cyc  = cyc + delta;
        sb.push_back(e);
    endtask

    // Holds requests until each is acked, dropping cmd at the posedge ending its ack cycle
    task automatic run_requests(input int budget);
        bit cs, ds;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            cs = c_ack;
            ds = d_ack;
            @(posedge clk);
            #1;
            if (cs) c_cmd = 2'b00;
            if (ds) d_cmd = 2'b00;
            if (c_cmd == 2'b00 && d_cmd == 2'b00) return;
        end
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("[TB] FAIL ack_timeout: c_cmd=%b d_cmd=%b still pending, required ack within %0d cycles",
                 c_cmd, d_cmd, budget);
        c_cmd = 2'b00;
        d_cmd = 2'b00;
    endtask

    task automatic single(input bit port, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] wdata, input bit chk, input logic [15:0] exp);
        if (port) begin
            d_cmd = cmd; d_addr = addr; d_wdata = wdata;
        end else begin
            c_cmd = cmd; c_addr = addr; c_wdata = wdata;
        end
        push_exp(port, chk, exp, 2);
        run_requests(8);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        c_cmd = 2'b00; d_cmd = 2'b00;
        c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;
        sw_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors = vectors + 1;
        if ({c_ack, d_ack, ram_write, busy} !== 4'b0000) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL reset_ctrl: ack/write/busy=%b, required 0000", {c_ack, d_ack, ram_write, busy});
        end
        vectors = vectors + 1;
        if ({c_rdata, d_rdata, led_out} !== 40'h0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL reset_data: c_rdata=%h d_rdata=%h led=%h, required 0", c_rdata, d_rdata, led_out);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors = vectors + 1;
        if (busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL idle_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_tie;
        c_cmd = 2'b10; c_addr = 9'h007;
        d_cmd = 2'b10; d_addr = 9'h009;
        push_exp(1'b0, 1'b1, 16'h1111, 2);
        push_exp(1'b1, 1'b1, 16'h2222, 4);
        run_requests(10);
        single(1'b0, 2'b10, 9'h009, 16'h0, 1'b1, 16'h2222);
        c_cmd = 2'b10; c_addr = 9'h009;
        d_cmd = 2'b10; d_addr = 9'h007;
        push_exp(1'b1, 1'b1, 16'h1111, 2);
        push_exp(1'b0, 1'b1, 16'h2222, 4);
        run_requests(10);
    endtask

    task automatic test_ram_rw;
        rw_cycles = 0;
        single(1'b0, 2'b01, 9'h005, 16'hBEEF, 1'b0, 16'h0);
        vectors = vectors + 1;
        if (rw_cycles !== 1 || mem[5] !== 16'hBEEF) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL ram_write: cycles=%0d mem[5]=%h, required 1 and beef", rw_cycles, mem[5]);
        end
        single(1'b0, 2'b10, 9'h005, 16'h0, 1'b1, 16'hBEEF);
        single(1'b1, 2'b10, 9'h005, 16'h0, 1'b1, 16'hBEEF);
        vectors = vectors + 1;
        if (c_rdata !== 16'hBEEF) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL c_rdata_hold: got %h, required beef", c_rdata);
        end
    endtask

    task automatic test_led;
        rw_cycles = 0;
        single(1'b0, 2'b01, 9'h100, 16'h00A5, 1'b0, 16'h0);
        vectors = vectors + 1;
        if (led_out !== 8'hA5 || rw_cycles !== 0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL led_write: led=%h ram_write cycles=%0d, required a5 and 0", led_out, rw_cycles);
        end
        single(1'b0, 2'b10, 9'h100, 16'h0, 1'b1, 16'h00A5);
    endtask

    task automatic test_sw_unmapped;
        sw_in = 8'h3C;
        rw_cycles = 0;
        single(1'b1, 2'b10, 9'h140, 16'h0, 1'b1, 16'h003C);
        vectors = vectors + 1;
        if (c_rdata !== 16'h00A5) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL c_rdata_hold2: got %h, required 00a5", c_rdata);
        end
        single(1'b1, 2'b01, 9'h140, 16'h1234, 1'b0, 16'h0);
        single(1'b0, 2'b01, 9'h1F0, 16'h5678, 1'b0, 16'h0);
        single(1'b0, 2'b10, 9'h1F0, 16'h0, 1'b1, 16'h0000);
        vectors = vectors + 1;
        if (led_out !== 8'hA5 || rw_cycles !== 0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL dropped_writes: led=%h ram_write cycles=%0d, required a5 and 0", led_out, rw_cycles);
        end
    endtask

    task automatic test_reset_mid_access;
        single(1'b0, 2'b01, 9'h010, 16'h5555, 1'b0, 16'h0);
        c_cmd = 2'b01; c_addr = 9'h010; c_wdata = 16'hDEAD;
        @(posedge clk);
        #1;
        vectors = vectors + 1;
        if (ram_write !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL access_write: ram_write=%b, required 1", ram_write);
        end
        #1 reset = 1'b1;
        #1;
        vectors = vectors + 1;
        if ({ram_write, busy, c_ack, d_ack} !== 4'b0000 || led_out !== 8'h00) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL reset_abort: write/busy/acks=%b led=%h, required 0000 and 00",
                     {ram_write, busy, c_ack, d_ack}, led_out);
        end
        c_cmd = 2'b00;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors = vectors + 1;
        if (mem[16] !== 16'h5555 || busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL aborted_write: mem[16]=%h busy=%b, required 5555 and 0", mem[16], busy);
        end
    endtask

    task automatic test_nop;
        c_cmd = 2'b11;
        d_cmd = 2'b11;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            vectors = vectors + 1;
            if ({busy, c_ack, d_ack} !== 3'b000) begin
                miscompares = miscompares + 1;
                $display("[TB] FAIL nop_idle: busy/c_ack/d_ack=%b, required 000", {busy, c_ack, d_ack});
            end
        end
        @(posedge clk);
        #1;
        c_cmd = 2'b00;
        d_cmd = 2'b00;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_ram_rw();
        test_led();
        test_sw_unmapped();
        test_reset_mid_access();
        test_nop();
        repeat (3) @(posedge clk);
        vectors = vectors + 1;
        if (sb.size() != 0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL scoreboard_drain: %0d acks outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
